// File: rtl/ahb3lite_sram_slave_if.sv
// AHB3-Lite slave-port bundle between an interconnect (master side) and a
// responder (slave side).
//   master modport: drives HSEL/HADDR/HWDATA/HWRITE/HSIZE/HBURST/HPROT/HTRANS/
//                   HMASTLOCK/HREADY, observes HRDATA/HREADYOUT/HRESP
//   slave modport : the mirror image
interface ahb3lite_sram_slave_if #(
  parameter int unsigned HADDR_SIZE = 32,
  parameter int unsigned HDATA_SIZE = 32
);
  logic                  HSEL;
  logic [HADDR_SIZE-1:0] HADDR;
  logic [HDATA_SIZE-1:0] HWDATA;
  logic [HDATA_SIZE-1:0] HRDATA;
  logic                  HWRITE;
  logic [2:0]            HSIZE;
  logic [2:0]            HBURST;
  logic [3:0]            HPROT;
  logic [1:0]            HTRANS;
  logic                  HMASTLOCK;
  logic                  HREADY;
  logic                  HREADYOUT;
  logic                  HRESP;

  modport master (
    output HSEL, HADDR, HWDATA, HWRITE, HSIZE, HBURST, HPROT, HTRANS,
           HMASTLOCK, HREADY,
    input  HRDATA, HREADYOUT, HRESP
  );

  modport slave (
    input  HSEL, HADDR, HWDATA, HWRITE, HSIZE, HBURST, HPROT, HTRANS,
           HMASTLOCK, HREADY,
    output HRDATA, HREADYOUT, HRESP
  );
endinterface

// File: rtl/ahb3lite_sram_slave.sv
// AHB3-Lite SRAM responder: flop-array memory, WAIT_STATES wait cycles per
// OKAY transfer, two-cycle ERROR response for bad size/alignment.
// Ports:
//   HCLK   - clock, rising edge
//   HRESET - asynchronous active-high reset
//   ahb    - slave side of ahb3lite_sram_slave_if (address/data phase in,
//            HRDATA/HREADYOUT/HRESP out)
// Optional feature: define AHB3LITE_SRAM_SLAVE_PROT_EN to reject user-mode
// (HPROT[1]=0) writes to the upper half of the memory with an ERROR response.
module ahb3lite_sram_slave #(
  parameter int unsigned HADDR_SIZE  = 32,
  parameter int unsigned HDATA_SIZE  = 32,
  parameter int unsigned MEM_DEPTH   = 256,
  parameter int unsigned WAIT_STATES = 0
) (
  input logic                  HCLK,
  input logic                  HRESET,
  ahb3lite_sram_slave_if.slave ahb
);

  localparam int unsigned BYTES = HDATA_SIZE / 8;
  localparam int unsigned LSB   = $clog2(BYTES);
  localparam int unsigned IDX   = $clog2(MEM_DEPTH);
  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ERR1 = 2'd2,
    ST_ERR2 = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               hreadyout_q, hreadyout_d;
  logic               hresp_q, hresp_d;
  logic               dp_q, dp_d;          // OKAY data phase in progress
  logic               wr_q, wr_d;
  logic [IDX-1:0]     idx_q, idx_d;
  logic [LSB-1:0]     off_q, off_d;
  logic [2:0]         size_q, size_d;

  logic [HADDR_SIZE-1:0] haddr_c;
  logic [LSB-1:0]        align_mask_c;
  logic                  accept_c;
  logic                  misalign_c;
  logic                  size_err_c;
  logic                  prot_err_c;
  logic                  acc_err_c;
  logic                  commit_c;
  logic                  rd_c;
  logic [BYTES-1:0]      be_c;
  logic [HDATA_SIZE-1:0] rdata_c;
  logic                  unused_c;

  // Address-phase decode
  assign haddr_c      = ahb.HADDR;
  assign accept_c     = ahb.HSEL & ahb.HREADY & ahb.HTRANS[1];
  assign align_mask_c = LSB'((32'd1 << ahb.HSIZE) - 32'd1);
  assign misalign_c   = |(haddr_c[LSB-1:0] & align_mask_c);
  assign size_err_c   = (ahb.HSIZE > 3'(LSB));

`ifdef AHB3LITE_SRAM_SLAVE_PROT_EN
  // Upper half of the array is writable only from privileged accesses
  assign prot_err_c = ahb.HWRITE & ~ahb.HPROT[1] & haddr_c[LSB+IDX-1];
`else
  assign prot_err_c = 1'b0;
`endif

  assign acc_err_c = size_err_c | misalign_c | prot_err_c;

  // Upper address bits, burst type and lock are decoded elsewhere
  assign unused_c = ^{haddr_c, ahb.HBURST, ahb.HMASTLOCK, ahb.HPROT, ahb.HTRANS[0]};

  // State and latched address-phase controls
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      hreadyout_q <= 1'b1;
      hresp_q     <= 1'b0;
      dp_q        <= 1'b0;
      wr_q        <= 1'b0;
      idx_q       <= '0;
      off_q       <= '0;
      size_q      <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      hreadyout_q <= hreadyout_d;
      hresp_q     <= hresp_d;
      dp_q        <= dp_d;
      wr_q        <= wr_d;
      idx_q       <= idx_d;
      off_q       <= off_d;
      size_q      <= size_d;
    end
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    hreadyout_d = hreadyout_q;
    hresp_d     = hresp_q;
    dp_d        = dp_q;
    wr_d        = wr_q;
    idx_d       = idx_q;
    off_d       = off_q;
    size_d      = size_q;

    // A data phase ends on any edge where we present ready
    if (hreadyout_q) begin
      dp_d = 1'b0;
    end

    unique case (state_q)
      ST_IDLE, ST_ERR2: begin
        state_d     = ST_IDLE;
        hreadyout_d = 1'b1;
        hresp_d     = 1'b0;
        if (accept_c) begin
          wr_d   = ahb.HWRITE;
          idx_d  = haddr_c[LSB+IDX-1:LSB];
          off_d  = haddr_c[LSB-1:0];
          size_d = ahb.HSIZE;
          if (acc_err_c) begin
            state_d     = ST_ERR1;
            hreadyout_d = 1'b0;
            hresp_d     = 1'b1;
          end else begin
            dp_d = 1'b1;
            if (WAIT_STATES != 0) begin
              state_d     = ST_WAIT;
              cnt_d       = 4'(WAIT_STATES);
              hreadyout_d = 1'b0;
            end
          end
        end
      end
      ST_WAIT: begin
        // Ready is raised for the cycle in which the count reaches zero
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d     = ST_IDLE;
          hreadyout_d = 1'b1;
        end
      end
      ST_ERR1: begin
        state_d     = ST_ERR2;
        hreadyout_d = 1'b1;
        hresp_d     = 1'b1;
      end
      default: begin
        state_d     = ST_IDLE;
        hreadyout_d = 1'b1;
        hresp_d     = 1'b0;
      end
    endcase
  end

  assign commit_c = dp_q & wr_q & hreadyout_q;
  assign rd_c     = dp_q & ~wr_q;

  // One byte-wide array per lane; a write touches only the addressed lanes
  for (genvar g = 0; g < BYTES; g++) begin : g_lane
    logic [7:0] lane_q [MEM_DEPTH];

    assign be_c[g] = (32'(g) >= 32'(off_q)) &&
                     (32'(g) <  32'(off_q) + (32'd1 << size_q));

    always_ff @(posedge HCLK) begin
      if (commit_c && be_c[g]) begin
        lane_q[idx_q] <= ahb.HWDATA[8*g +: 8];
      end
    end

    assign rdata_c[8*g +: 8] = lane_q[idx_q];
  end

  assign ahb.HRDATA    = rd_c ? rdata_c : '0;
  assign ahb.HREADYOUT = hreadyout_q;
  assign ahb.HRESP     = hresp_q;

endmodule

// File: tb/tb_ahb3lite_sram_slave.sv
// Self-checking bench for ahb3lite_sram_slave: a zero-wait instance driven
// from a per-cycle vector table and a three-wait instance driven by
// hand-written sequences (wait counting, reset in the middle of a transfer).
module tb_ahb3lite_sram_slave;

  localparam int unsigned IDL = 0;
  localparam int unsigned BSY = 1;
  localparam int unsigned NSQ = 2;
  localparam int unsigned SQ  = 3;

  typedef struct {
    logic        sel;
    logic [1:0]  trans;
    logic        write;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [3:0]  prot;
    logic        ready;
    logic [31:0] wdata;
    logic        exp_rdy;
    logic        exp_resp;
    logic [31:0] exp_rdata;
  } vec_t;

  logic HCLK;
  logic HRESET;
  int   checks;
  int   failures;
  vec_t tab [$];

  ahb3lite_sram_slave_if #(.HADDR_SIZE(32), .HDATA_SIZE(32)) bus0 ();
  ahb3lite_sram_slave_if #(.HADDR_SIZE(32), .HDATA_SIZE(32)) bus3 ();

  ahb3lite_sram_slave #(
    .HADDR_SIZE(32), .HDATA_SIZE(32), .MEM_DEPTH(256), .WAIT_STATES(0)
  ) dut0 (
    .HCLK   (HCLK),
    .HRESET (HRESET),
    .ahb    (bus0)
  );

  ahb3lite_sram_slave #(
    .HADDR_SIZE(32), .HDATA_SIZE(32), .MEM_DEPTH(256), .WAIT_STATES(3)
  ) dut3 (
    .HCLK   (HCLK),
    .HRESET (HRESET),
    .ahb    (bus3)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  function automatic vec_t mk(input int unsigned sel, input int unsigned tr,
                              input int unsigned wr, input logic [31:0] addr,
                              input int unsigned sz, input int unsigned prot,
                              input int unsigned rdy, input logic [31:0] wdata,
                              input int unsigned erdy, input int unsigned eresp,
                              input logic [31:0] edata);
    vec_t t;
    t.sel       = 1'(sel);
    t.trans     = 2'(tr);
    t.write     = 1'(wr);
    t.addr      = addr;
    t.size      = 3'(sz);
    t.prot      = 4'(prot);
    t.ready     = 1'(rdy);
    t.wdata     = wdata;
    t.exp_rdy   = 1'(erdy);
    t.exp_resp  = 1'(eresp);
    t.exp_rdata = edata;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  // One bus cycle on the zero-wait instance: drive address phase + data-phase
  // write data, then check the outputs of the data phase now in progress
  task automatic step0(input vec_t t, input int n);
    @(negedge HCLK);
    bus0.HSEL   = t.sel;
    bus0.HTRANS = t.trans;
    bus0.HWRITE = t.write;
    bus0.HADDR  = t.addr;
    bus0.HSIZE  = t.size;
    bus0.HPROT  = t.prot;
    bus0.HREADY = t.ready;
    bus0.HWDATA = t.wdata;
    #1;
    chk($sformatf("vec%0d.hreadyout", n), 32'(bus0.HREADYOUT), 32'(t.exp_rdy));
    chk($sformatf("vec%0d.hresp", n),     32'(bus0.HRESP),     32'(t.exp_resp));
    chk($sformatf("vec%0d.hrdata", n),    bus0.HRDATA,         t.exp_rdata);
  endtask

  // Follow a wait-stated data phase on bus3, returning the low-ready count;
  // returns #1 after the negedge of the cycle in which HREADYOUT is high
  task automatic d3_wait(output int lows);
    lows = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge HCLK);
      bus3.HTRANS = 2'(IDL);
      bus3.HREADY = bus3.HREADYOUT;
      #1;
      if (bus3.HREADYOUT === 1'b1) break;
      lows++;
    end
  endtask

  initial begin
    int lows;
    checks   = 0;
    failures = 0;

    bus0.HSEL = 1'b0; bus0.HADDR = '0; bus0.HWDATA = '0; bus0.HWRITE = 1'b0;
    bus0.HSIZE = 3'd2; bus0.HBURST = 3'd0; bus0.HPROT = 4'h3;
    bus0.HTRANS = 2'd0; bus0.HMASTLOCK = 1'b0; bus0.HREADY = 1'b1;
    bus3.HSEL = 1'b0; bus3.HADDR = '0; bus3.HWDATA = '0; bus3.HWRITE = 1'b0;
    bus3.HSIZE = 3'd2; bus3.HBURST = 3'd0; bus3.HPROT = 4'h3;
    bus3.HTRANS = 2'd0; bus3.HMASTLOCK = 1'b0; bus3.HREADY = 1'b1;

    // sel, trans, write, addr, size, prot, hready, wdata, exp rdy, exp resp, exp rdata
    tab.push_back(mk(1, IDL, 0, 'h00, 2, 3, 1, 'h0,        1, 0, 'h0));
    tab.push_back(mk(1, NSQ, 1, 'h10, 2, 3, 1, 'h0,        1, 0, 'h0));
    tab.push_back(mk(1, NSQ, 0, 'h10, 2, 3, 1, 'hDEADBEEF, 1, 0, 'h0));
    tab.push_back(mk(1, NSQ, 1, 'h10, 2, 3, 1, 'h0,        1, 0, 'hDEADBEEF));
    tab.push_back(mk(1, NSQ, 1, 'h13, 0, 3, 1, 'h11223344, 1, 0, 'h0));
    tab.push_back(mk(1, NSQ, 0, 'h10, 2, 3, 1, 'hAA000000, 1, 0, 'h0));
    tab.push_back(mk(1, IDL, 0, 'h00, 2, 3, 1, 'h0,        1, 0, 'hAA223344));
    tab.push_back(mk(1, NSQ, 1, 'h20, 2, 3, 1, 'h0,        1, 0, 'h0));
    tab.push_back(mk(1, SQ,  0, 'h20, 2, 3, 1, 'h5A5A5A5A, 1, 0, 'h0));
    tab.push_back(mk(1, IDL, 0, 'h00, 2, 3, 1, 'h0,        1, 0, 'h5A5A5A5A));
    tab.push_back(mk(1, NSQ, 1, 'h20, 2, 3, 0, 'h0,        1, 0, 'h0));
    tab.push_back(mk(1, NSQ, 0, 'h20, 2, 3, 1, 'hFFFFFFFF, 1, 0, 'h0));
    tab.push_back(mk(1, IDL, 0, 'h00, 2, 3, 1, 'h0,        1, 0, 'h5A5A5A5A));
    tab.push_back(mk(1, NSQ, 1, 'h11, 1, 3, 1, 'h0,        1, 0, 'h0));
    tab.push_back(mk(1, NSQ, 0, 'h10, 2, 3, 0, 'h0000FFFF, 0, 1, 'h0));
    tab.push_back(mk(1, NSQ, 0, 'h10, 2, 3, 1, 'h0,        1, 1, 'h0));
    tab.push_back(mk(1, IDL, 0, 'h00, 2, 3, 1, 'h0,        1, 0, 'hAA223344));
    tab.push_back(mk(1, NSQ, 1, 'h10, 3, 3, 1, 'h0,        1, 0, 'h0));
    tab.push_back(mk(1, IDL, 0, 'h00, 2, 3, 0, 'h12345678, 0, 1, 'h0));
    tab.push_back(mk(1, IDL, 0, 'h00, 2, 3, 1, 'h0,        1, 1, 'h0));
    tab.push_back(mk(1, NSQ, 0, 'h10, 2, 3, 1, 'h0,        1, 0, 'h0));
    tab.push_back(mk(1, IDL, 0, 'h00, 2, 3, 1, 'h0,        1, 0, 'hAA223344));
    tab.push_back(mk(1, NSQ, 1, 'h22, 1, 3, 1, 'h0,        1, 0, 'h0));
    tab.push_back(mk(1, BSY, 1, 'h20, 2, 3, 1, 'hBEEF0000, 1, 0, 'h0));
    tab.push_back(mk(1, NSQ, 0, 'h20, 2, 3, 1, 'h0,        1, 0, 'h0));
    tab.push_back(mk(0, NSQ, 1, 'h20, 2, 3, 1, 'h0,        1, 0, 'hBEEF5A5A));
    tab.push_back(mk(1, NSQ, 0, 'h20, 2, 3, 1, 'hFFFFFFFF, 1, 0, 'h0));
    tab.push_back(mk(1, IDL, 0, 'h00, 2, 3, 1, 'h0,        1, 0, 'hBEEF5A5A));
    tab.push_back(mk(1, NSQ, 1, 'h20, 1, 3, 1, 'h0,        1, 0, 'h0));
    tab.push_back(mk(1, IDL, 0, 'h00, 2, 3, 1, 'h00001234, 1, 0, 'h0));
    tab.push_back(mk(1, NSQ, 0, 'h20, 2, 3, 1, 'h0,        1, 0, 'h0));
    tab.push_back(mk(1, IDL, 0, 'h00, 2, 3, 1, 'h0,        1, 0, 'hBEEF1234));
    // word 200 (0x320): privileged write, then a user-mode write
    tab.push_back(mk(1, NSQ, 1, 'h320, 2, 3, 1, 'h0,        1, 0, 'h0));
    tab.push_back(mk(1, IDL, 0, 'h000, 2, 3, 1, 'h01020304, 1, 0, 'h0));
    tab.push_back(mk(1, NSQ, 1, 'h320, 2, 1, 1, 'h0,        1, 0, 'h0));
`ifdef AHB3LITE_SRAM_SLAVE_PROT_EN
    tab.push_back(mk(1, IDL, 0, 'h000, 2, 3, 0, 'hFFFFFFFF, 0, 1, 'h0));
    tab.push_back(mk(1, NSQ, 0, 'h320, 2, 1, 1, 'h0,        1, 1, 'h0));
    tab.push_back(mk(1, IDL, 0, 'h000, 2, 3, 1, 'h0,        1, 0, 'h01020304));
`else
    tab.push_back(mk(1, IDL, 0, 'h000, 2, 3, 1, 'hFFFFFFFF, 1, 0, 'h0));
    tab.push_back(mk(1, NSQ, 0, 'h320, 2, 1, 1, 'h0,        1, 0, 'h0));
    tab.push_back(mk(1, IDL, 0, 'h000, 2, 3, 1, 'h0,        1, 0, 'hFFFFFFFF));
`endif
    tab.push_back(mk(1, NSQ, 1, 'h320, 2, 3, 1, 'h0,        1, 0, 'h0));
    tab.push_back(mk(1, NSQ, 0, 'h320, 2, 1, 1, 'hCAFEF00D, 1, 0, 'h0));
    tab.push_back(mk(1, IDL, 0, 'h000, 2, 3, 1, 'h0,        1, 0, 'hCAFEF00D));
    tab.push_back(mk(1, NSQ, 1, 'h030, 2, 1, 1, 'h0,        1, 0, 'h0));
    tab.push_back(mk(1, NSQ, 0, 'h030, 2, 1, 1, 'h600DD00D, 1, 0, 'h0));
    tab.push_back(mk(1, IDL, 0, 'h000, 2, 3, 1, 'h0,        1, 0, 'h600DD00D));

    HRESET = 1'b1;
    repeat (2) @(negedge HCLK);
    HRESET = 1'b0;

    for (int i = 0; i < tab.size(); i++) begin
      step0(tab[i], i);
    end

    // Three-wait instance: write, then a read pipelined into the last write cycle
    @(negedge HCLK);
    bus3.HSEL = 1'b1; bus3.HTRANS = 2'(NSQ); bus3.HWRITE = 1'b1;
    bus3.HADDR = 32'h40; bus3.HSIZE = 3'd2; bus3.HREADY = 1'b1;
    bus3.HWDATA = 32'h12345678;
    #1;
    chk("ws.addr_rdy", 32'(bus3.HREADYOUT), 32'd1);
    d3_wait(lows);
    chk("ws.write_lows", 32'(lows), 32'd3);
    chk("ws.write_resp", 32'(bus3.HRESP), 32'd0);
    bus3.HTRANS = 2'(NSQ); bus3.HWRITE = 1'b0; bus3.HREADY = 1'b1;
    d3_wait(lows);
    chk("ws.read_lows", 32'(lows), 32'd3);
    chk("ws.read_resp", 32'(bus3.HRESP), 32'd0);
    chk("ws.read_data", bus3.HRDATA, 32'h12345678);

    // Reset during the wait of a write: state aborts, write is dropped
    bus3.HTRANS = 2'(NSQ); bus3.HWRITE = 1'b1; bus3.HWDATA = 32'h99999999;
    @(negedge HCLK);
    bus3.HTRANS = 2'(IDL); bus3.HREADY = 1'b0;
    #1;
    chk("rst1.pre_rdy", 32'(bus3.HREADYOUT), 32'd0);
    #2 HRESET = 1'b1;
    #1;
    chk("rst1.rdy", 32'(bus3.HREADYOUT), 32'd1);
    chk("rst1.resp", 32'(bus3.HRESP), 32'd0);
    chk("rst1.rdata", bus3.HRDATA, 32'h0);
    @(negedge HCLK);
    HRESET = 1'b0;
    bus3.HREADY = 1'b1;

    @(negedge HCLK);
    bus3.HTRANS = 2'(NSQ); bus3.HWRITE = 1'b0; bus3.HADDR = 32'h40;
    d3_wait(lows);
    chk("rst1.read_lows", 32'(lows), 32'd3);
    chk("rst1.read_data", bus3.HRDATA, 32'h12345678);

    // Reset during the wait of a read
    bus3.HTRANS = 2'(NSQ); bus3.HWRITE = 1'b0;
    @(negedge HCLK);
    bus3.HTRANS = 2'(IDL); bus3.HREADY = 1'b0;
    #1;
    chk("rst2.pre_rdy", 32'(bus3.HREADYOUT), 32'd0);
    #2 HRESET = 1'b1;
    #1;
    chk("rst2.rdy", 32'(bus3.HREADYOUT), 32'd1);
    chk("rst2.resp", 32'(bus3.HRESP), 32'd0);
    chk("rst2.rdata", bus3.HRDATA, 32'h0);
    @(negedge HCLK);
    HRESET = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
